// File: rtl/rom_ctrl.sv
// Fixed 8x8 constant lookup table addressed by a one-hot select, with a
// combinational read path and a registered illegal-address flag.
module rom_ctrl (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_en,
   input  logic [7:0] i_addr,
   output logic [7:0] o_data,
   output logic       o_err
);

   logic [7:0] rom [8];

   assign rom[0] = 8'h3C;
   assign rom[1] = 8'hA5;
   assign rom[2] = 8'h5A;
   assign rom[3] = 8'hC3;
   assign rom[4] = 8'h0F;
   assign rom[5] = 8'hF0;
   assign rom[6] = 8'h96;
   assign rom[7] = 8'h69;

   // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
   logic [7:0] addr_m1;
   logic       addr_onehot;

   assign addr_m1     = i_addr - 8'd1;
   assign addr_onehot = (i_addr != 8'h00) && ((i_addr & addr_m1) == 8'h00);

   // AND-OR mux; only valid for a one-hot select, so illegal selects are forced to zero.
   logic [7:0] rd_mux;

   always_comb begin
      rd_mux = 8'h00;
      for (int k = 0; k < 8; k++) begin
         rd_mux = rd_mux | (rom[k] & {8{i_addr[k]}});
      end
   end

   // The enable gates first so a disabled read stays 8'h00 even for unknown addresses.
   assign o_data = i_en ? (addr_onehot ? rd_mux : 8'h00) : 8'h00;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_err <= 1'b0;
      end else begin
         o_err <= i_en & ~addr_onehot;
      end
   end

endmodule

// File: tb/tb_rom_ctrl.sv
// Self-checking bench for rom_ctrl: directed cases followed by randomized
// requests, compared against a table-driven reference model.
module tb_rom_ctrl;

   logic       i_clk;
   logic       i_rst;
   logic       i_en;
   logic [7:0] i_addr;
   logic [7:0] o_data;
   logic       o_err;

   int n_cmp = 0;
   int n_bad = 0;

   logic [0:0] exp_q[$];

   rom_ctrl dut (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_en   (i_en),
      .i_addr (i_addr),
      .o_data (o_data),
      .o_err  (o_err)
   );

   // Clock / reset block
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   initial begin
      i_rst  = 1'b1;
      i_en   = 1'b0;
      i_addr = 8'h00;
   end

   // Reference model
   function automatic logic [7:0] table_val(input int k);
      logic [7:0] tbl [8];
      tbl = '{8'h3C, 8'hA5, 8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h96, 8'h69};
      return tbl[k];
   endfunction

   function automatic int popcount(input logic [7:0] v);
      int c = 0;
      for (int b = 0; b < 8; b++) c += v[b];
      return c;
   endfunction

   function automatic logic [7:0] model_data(input logic en, input logic [7:0] addr);
      if (!en || popcount(addr) != 1) return 8'h00;
      for (int b = 0; b < 8; b++) if (addr[b]) return table_val(b);
      return 8'h00;
   endfunction

   function automatic logic model_err(input logic rst, input logic en, input logic [7:0] addr);
      if (rst) return 1'b0;
      return en && (popcount(addr) != 1);
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Driver: apply at falling edge, check data before the rising edge,
   // then check the registered flag just after it.
   task automatic step(input string tag, input logic rst, input logic en, input logic [7:0] addr);
      logic [0:0] e;
      @(negedge i_clk);
      i_rst  = rst;
      i_en   = en;
      i_addr = addr;
      #4;
      check({tag, "_data"}, o_data, model_data(en, addr));
      exp_q.push_back(model_err(rst, en, addr));
      @(posedge i_clk);
      #1;
      e = exp_q.pop_front();
      check({tag, "_err"}, {7'd0, o_err}, {7'd0, e});
   endtask

   initial begin
      logic [7:0] a;
      logic       en_r;
      logic       rst_r;

      step("reset", 1'b1, 1'b0, 8'h04);
      step("dis_after_rst", 1'b0, 1'b0, 8'h04);

      for (int k = 0; k < 8; k++) step($sformatf("onehot%0d", k), 1'b0, 1'b1, 8'h01 << k);

      step("zero_addr", 1'b0, 1'b1, 8'h00);
      step("two_bits", 1'b0, 1'b1, 8'h03);
      step("recover", 1'b0, 1'b1, 8'h80);
      step("dis_illegal", 1'b0, 1'b0, 8'h05);
      step("rst_wins", 1'b1, 1'b1, 8'hFF);
      step("rst_release", 1'b0, 1'b1, 8'hFF);
      step("tog_on", 1'b0, 1'b1, 8'h10);
      step("tog_off", 1'b0, 1'b0, 8'h10);
      step("tog_on2", 1'b0, 1'b1, 8'h10);

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 1) == 0) a = 8'h01 << $urandom_range(0, 7);
         else                           a = 8'($urandom_range(0, 255));
         en_r  = ($urandom_range(0, 3) != 0);
         rst_r = ($urandom_range(0, 15) == 0);
         step("rand", rst_r, en_r, a);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
